// File: rtl/rf_wb_ctrl_pkg.sv
// Shared register-file constants and controller state encoding.
package rf_wb_ctrl_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DEPTH  = 32;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Synchronous write-back queue of {addr,data}; exposes entries oldest-first
// so the controller can forward the youngest matching entry.
module rf_wb_fifo
  import rf_wb_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               push,
  input  logic                               pop,
  input  logic [RF_ADDR_W-1:0]               push_addr,
  input  logic [DATA_W-1:0]                  push_data,
  output logic [RF_ADDR_W-1:0]               head_addr,
  output logic [DATA_W-1:0]                  head_data,
  output logic                               full,
  output logic                               empty,
  output logic [$clog2(DEPTH):0]             count,
  output logic [DEPTH-1:0]                   age_valid,
  output logic [DEPTH-1:0][RF_ADDR_W-1:0]    age_addr,
  output logic [DEPTH-1:0][DATA_W-1:0]       age_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [RF_ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0]    mem_data [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign head_addr = mem_addr[rd_ptr];
  assign head_data = mem_data[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_addr[wr_ptr] <= push_addr;
      mem_data[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Index 0 is the head (oldest); higher indices are younger.
  always_comb begin
    age_valid = '0;
    age_addr  = '0;
    age_data  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age_valid[i] = ((PTR_W + 1)'(i) < count);
      age_addr[i]  = mem_addr[rd_ptr + PTR_W'(i)];
      age_data[i]  = mem_data[rd_ptr + PTR_W'(i)];
    end
  end

endmodule

// File: rtl/rf_wb_ctrl.sv
// Register-file write-port controller: zero-fill sweep after reset, then host
// priority over a queued datapath write-back, with operand forwarding.
module rf_wb_ctrl
  import rf_wb_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                   WCLK,
  input  logic                   RSTN,
  input  logic                   WB_VALID,
  output logic                   WB_READY,
  input  logic [RF_ADDR_W-1:0]   WB_ADDR,
  input  logic [DATA_W-1:0]      WB_DATA,
  input  logic                   HOST_WE,
  input  logic [RF_ADDR_W-1:0]   HOST_ADDR,
  input  logic [DATA_W-1:0]      HOST_DATA,
  output logic                   RF_WE,
  output logic [RF_ADDR_W-1:0]   RF_ADDRD,
  output logic [DATA_W-1:0]      RF_DIN,
  input  logic [RF_ADDR_W-1:0]   RD_ADDRA,
  input  logic [RF_ADDR_W-1:0]   RD_ADDRB,
  input  logic [RF_ADDR_W-1:0]   RD_ADDRC,
  input  logic [DATA_W-1:0]      RF_DOA,
  input  logic [DATA_W-1:0]      RF_DOB,
  input  logic [DATA_W-1:0]      RF_DOC,
  output logic [DATA_W-1:0]      OPA,
  output logic [DATA_W-1:0]      OPB,
  output logic [DATA_W-1:0]      OPC,
  output logic                   INIT_DONE,
  output logic [$clog2(DEPTH):0] PENDING
);

  state_t                          state;
  logic [RF_ADDR_W-1:0]            sweep;
  logic                            init_done_q;
  logic                            push;
  logic                            pop;
  logic                            fifo_full;
  logic                            fifo_empty;
  logic [RF_ADDR_W-1:0]            head_addr;
  logic [DATA_W-1:0]               head_data;
  logic [DEPTH-1:0]                age_valid;
  logic [DEPTH-1:0][RF_ADDR_W-1:0] age_addr;
  logic [DEPTH-1:0][DATA_W-1:0]    age_data;
  logic [2:0][RF_ADDR_W-1:0]       rd_addr;
  logic [2:0][DATA_W-1:0]          rd_data;
  logic [2:0][DATA_W-1:0]          fwd;

  always_ff @(posedge WCLK or negedge RSTN) begin
    if (!RSTN) begin
      state       <= ST_INIT;
      sweep       <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          sweep <= sweep + 1'b1;
          if (sweep == RF_ADDR_W'(RF_DEPTH - 1)) begin
            state       <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        default: init_done_q <= 1'b1;
      endcase
    end
  end

  assign INIT_DONE = init_done_q;
  assign WB_READY  = (state == ST_RUN) & ~fifo_full;
  assign push      = WB_VALID & WB_READY;
  assign pop       = (state == ST_RUN) & ~HOST_WE & ~fifo_empty;

  rf_wb_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (WCLK),
    .rst_n     (RSTN),
    .push      (push),
    .pop       (pop),
    .push_addr (WB_ADDR),
    .push_data (WB_DATA),
    .head_addr (head_addr),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (PENDING),
    .age_valid (age_valid),
    .age_addr  (age_addr),
    .age_data  (age_data)
  );

  // The sweep write is gated by RSTN so nothing reaches the RF while held in reset.
  always_comb begin
    RF_WE    = 1'b0;
    RF_ADDRD = '0;
    RF_DIN   = '0;
    if (state == ST_INIT) begin
      RF_WE    = RSTN;
      RF_ADDRD = sweep;
    end else if (HOST_WE) begin
      RF_WE    = 1'b1;
      RF_ADDRD = HOST_ADDR;
      RF_DIN   = HOST_DATA;
    end else if (!fifo_empty) begin
      RF_WE    = 1'b1;
      RF_ADDRD = head_addr;
      RF_DIN   = head_data;
    end
  end

  assign rd_addr = {RD_ADDRC, RD_ADDRB, RD_ADDRA};
  assign rd_data = {RF_DOC, RF_DOB, RF_DOA};

  // Queued entries are newer than the host write, so they override it; later
  // (younger) queue entries override older ones.
  always_comb begin
    fwd = '0;
    for (int p = 0; p < 3; p++) begin
      fwd[p] = rd_data[p];
      if (HOST_WE && (HOST_ADDR == rd_addr[p])) fwd[p] = HOST_DATA;
      for (int i = 0; i < DEPTH; i++) begin
        if (age_valid[i] && (age_addr[i] == rd_addr[p])) fwd[p] = age_data[i];
      end
      if (state == ST_INIT) fwd[p] = '0;
    end
  end

  assign OPA = fwd[0];
  assign OPB = fwd[1];
  assign OPC = fwd[2];

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Directed bench for rf_wb_ctrl: a scoreboard monitor checks every RF write
// in order, while the main thread checks handshake, occupancy and forwarding.
module tb_rf_wb_ctrl;
  import rf_wb_ctrl_pkg::*;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;

  typedef struct packed {
    logic [4:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic        WCLK = 1'b0;
  logic        RSTN;
  logic        WB_VALID, WB_READY, HOST_WE, RF_WE, INIT_DONE;
  logic [4:0]  WB_ADDR, HOST_ADDR, RF_ADDRD, RD_ADDRA, RD_ADDRB, RD_ADDRC;
  logic [15:0] WB_DATA, HOST_DATA, RF_DIN, RF_DOA, RF_DOB, RF_DOC, OPA, OPB, OPC;
  logic [2:0]  PENDING;

  logic [15:0] rf_model [32];
  bit          rf_seeded = 1'b0;
  wr_t         exp_q [$];
  int          checks = 0;
  int          passes = 0;

  int ready_tbl [12] = '{1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
  int pend_tbl  [12] = '{0, 1, 2, 3, 4, 4, 4, 3, 3, 2, 1, 0};

  rf_wb_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .WCLK(WCLK), .RSTN(RSTN),
    .WB_VALID(WB_VALID), .WB_READY(WB_READY), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
    .HOST_WE(HOST_WE), .HOST_ADDR(HOST_ADDR), .HOST_DATA(HOST_DATA),
    .RF_WE(RF_WE), .RF_ADDRD(RF_ADDRD), .RF_DIN(RF_DIN),
    .RD_ADDRA(RD_ADDRA), .RD_ADDRB(RD_ADDRB), .RD_ADDRC(RD_ADDRC),
    .RF_DOA(RF_DOA), .RF_DOB(RF_DOB), .RF_DOC(RF_DOC),
    .OPA(OPA), .OPB(OPB), .OPC(OPC),
    .INIT_DONE(INIT_DONE), .PENDING(PENDING)
  );

  always #5 WCLK = ~WCLK;

  // Register-file model: seeded with a non-zero pattern so zero-forcing is visible.
  always @(posedge WCLK) begin
    if (!rf_seeded) begin
      for (int i = 0; i < 32; i++) rf_model[i] <= 16'hDEAD;
      rf_seeded <= 1'b1;
    end else if (RF_WE) begin
      rf_model[RF_ADDRD] <= RF_DIN;
    end
  end

  assign RF_DOA = rf_model[RD_ADDRA];
  assign RF_DOB = rf_model[RD_ADDRB];
  assign RF_DOC = rf_model[RD_ADDRC];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic hw, input logic [4:0] ha, input logic [15:0] hd,
                               input logic wv, input logic [4:0] wa, input logic [15:0] wd);
    HOST_WE   = hw;
    HOST_ADDR = ha;
    HOST_DATA = hd;
    WB_VALID  = wv;
    WB_ADDR   = wa;
    WB_DATA   = wd;
  endtask

  task automatic expectWrite(input logic [4:0] a, input logic [15:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge WCLK);
    #1;
  endtask

  // Runs the 32-cycle sweep with host and write-back activity that must be ignored.
  task automatic runInit();
    for (int i = 0; i < 32; i++) expectWrite(5'(i), 16'h0000);
    tick();
    RSTN = 1'b1;
    applyStimulus(1'b1, 5'd31, 16'h5555, 1'b1, 5'd2, 16'h7777);
    RD_ADDRA = 5'd31;
    RD_ADDRB = 5'd31;
    RD_ADDRC = 5'd0;
    for (int i = 0; i < 32; i++) begin
      @(negedge WCLK);
      checkOutput("init_done_low", INIT_DONE, 0);
      checkOutput("init_ready_low", WB_READY, 0);
      checkOutput("init_opa_zero", OPA, 0);
      checkOutput("init_opb_zero", OPB, 0);
      tick();
    end
    applyStimulus(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0);
    @(negedge WCLK);
    checkOutput("init_done_high", INIT_DONE, 1);
    checkOutput("run_ready", WB_READY, 1);
    checkOutput("run_pending", PENDING, 0);
    tick();
  endtask

  // Scoreboard monitor: every RF write must match the oldest expectation.
  initial begin
    wr_t e;
    forever begin
      @(negedge WCLK);
      if (RF_WE) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_write: got addr %0d data %h, expected no write",
                   RF_ADDRD, RF_DIN);
        end else begin
          e = exp_q.pop_front();
          checkOutput("rf_write", {11'b0, RF_ADDRD, RF_DIN}, {11'b0, e.addr, e.data});
        end
      end
    end
  end

  initial begin
    int acc;
    RSTN = 1'b0;
    applyStimulus(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0);
    RD_ADDRA = 5'd0;
    RD_ADDRB = 5'd0;
    RD_ADDRC = 5'd0;
    repeat (2) @(posedge WCLK);
    @(negedge WCLK);
    checkOutput("rst_rf_we", RF_WE, 0);
    checkOutput("rst_ready", WB_READY, 0);
    checkOutput("rst_pending", PENDING, 0);
    checkOutput("rst_init_done", INIT_DONE, 0);
    runInit();

    // Single write-back: one-cycle latency, forwarded then read from RF.
    expectWrite(5'd3, 16'h00AA);
    applyStimulus(1'b0, 5'd0, 16'h0, 1'b1, 5'd3, 16'h00AA);
    RD_ADDRA = 5'd3;
    @(negedge WCLK);
    checkOutput("s1_ready", WB_READY, 1);
    tick();
    applyStimulus(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0);
    @(negedge WCLK);
    checkOutput("s1_opa_queued", OPA, 16'h00AA);
    checkOutput("s1_pending", PENDING, 1);
    tick();
    @(negedge WCLK);
    checkOutput("s1_opa_rf", OPA, 16'h00AA);
    checkOutput("s1_pending_drained", PENDING, 0);
    tick();

    // Host holds port D for 6 cycles while 5 write-backs are offered.
    for (int i = 0; i < 6; i++) expectWrite(5'(10 + i), 16'(16'hB000 + i));
    for (int i = 0; i < 5; i++) expectWrite(5'(16 + i), 16'(16'hC000 + i));
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      applyStimulus(c < 6, 5'(10 + c), 16'(16'hB000 + c), acc < 5, 5'(16 + acc),
                    16'(16'hC000 + acc));
      @(negedge WCLK);
      checkOutput($sformatf("s2_ready_c%0d", c), WB_READY, ready_tbl[c]);
      checkOutput($sformatf("s2_pending_c%0d", c), PENDING, pend_tbl[c]);
      if (WB_VALID && WB_READY) acc++;
      tick();
    end
    applyStimulus(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0);

    // Two queued writes to the same register: youngest wins forwarding.
    for (int i = 0; i < 3; i++) expectWrite(5'd9, 16'(16'h0900 + i));
    expectWrite(5'd5, 16'h1111);
    expectWrite(5'd5, 16'h2222);
    RD_ADDRB = 5'd5;
    applyStimulus(1'b1, 5'd9, 16'h0900, 1'b1, 5'd5, 16'h1111);
    @(negedge WCLK);
    checkOutput("s3_ready0", WB_READY, 1);
    tick();
    applyStimulus(1'b1, 5'd9, 16'h0901, 1'b1, 5'd5, 16'h2222);
    @(negedge WCLK);
    checkOutput("s3_opb_one", OPB, 16'h1111);
    tick();
    applyStimulus(1'b1, 5'd9, 16'h0902, 1'b0, 5'd0, 16'h0);
    @(negedge WCLK);
    checkOutput("s3_opb_both", OPB, 16'h2222);
    checkOutput("s3_pending", PENDING, 2);
    tick();
    applyStimulus(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge WCLK);
      checkOutput($sformatf("s3_opb_drain%0d", c), OPB, 16'h2222);
      tick();
    end

    // Queue entry outranks a same-cycle host write to the same register.
    expectWrite(5'd8, 16'h0808);
    expectWrite(5'd7, 16'h0F0F);
    expectWrite(5'd7, 16'h1234);
    RD_ADDRA = 5'd8;
    RD_ADDRC = 5'd7;
    applyStimulus(1'b1, 5'd8, 16'h0808, 1'b1, 5'd7, 16'h1234);
    @(negedge WCLK);
    checkOutput("s4_opa_host", OPA, 16'h0808);
    checkOutput("s4_opc_pre", OPC, 16'h0000);
    tick();
    applyStimulus(1'b1, 5'd7, 16'h0F0F, 1'b0, 5'd0, 16'h0);
    @(negedge WCLK);
    checkOutput("s4_opc_queue_wins", OPC, 16'h1234);
    tick();
    applyStimulus(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0);
    @(negedge WCLK);
    checkOutput("s4_opc_draining", OPC, 16'h1234);
    tick();
    @(negedge WCLK);
    checkOutput("s4_opc_rf", OPC, 16'h1234);
    checkOutput("s4_opa_rf", OPA, 16'h0808);
    tick();

    // Reset with three queued entries: they must vanish without being written.
    for (int i = 0; i < 4; i++) expectWrite(5'd1, 16'(16'h0100 + i));
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 5'd1, 16'(16'h0100 + c), 1'b1, 5'(25 + c), 16'(16'hD000 + c));
      tick();
    end
    applyStimulus(1'b1, 5'd1, 16'h0103, 1'b0, 5'd0, 16'h0);
    @(negedge WCLK);
    checkOutput("s5_pending_pre", PENDING, 3);
    #1;
    RSTN = 1'b0;
    applyStimulus(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0);
    #1;
    checkOutput("s5_pending_rst", PENDING, 0);
    checkOutput("s5_rf_we_rst", RF_WE, 0);
    checkOutput("s5_ready_rst", WB_READY, 0);
    checkOutput("s5_init_done_rst", INIT_DONE, 0);
    @(posedge WCLK);
    runInit();
    for (int c = 0; c < 4; c++) begin
      @(negedge WCLK);
      checkOutput("s5_idle_pending", PENDING, 0);
      tick();
    end

    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
